square_rr_scheduler: RTL and testbench

// - Shares one registered squarer datapath (the `top` block: n[3:0] in, n2[7:0] = n*n out) between NREQ requesters.
// - Each requester presents operands on a valid/ready handshake.
// - Round-robin grant, one issue per cycle.
// - Tracks in-flight operations with a tag pipeline and returns each result tagged with the requester ID.
// - Sits between the requester clients and the squarer instance.

---
 rtl/square_rr_scheduler_pkg.sv | 18 +
 rtl/square_rr_scheduler_if.sv | 35 +++
 rtl/square_rr_scheduler_arb.sv | 42 ++++
 rtl/square_rr_scheduler.sv | 90 +++++++++
 tb/tb_square_rr_scheduler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/square_rr_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// square_sched_pkg
// Purpose : Shared constants and helpers for the round-robin squarer
//           scheduler: default operand and result widths, and the ID width
//           rule used to size requester indices.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package square_sched_pkg;

    localparam int W_IN  = 4;   // squarer operand width
    localparam int W_OUT = 8;   // squarer result width (2*W_IN)

    // Width of a requester index; a single requester still gets one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/square_rr_scheduler_if.sv
// ----------------------------------------------------------------------------
// square_rr_scheduler_if
// Purpose : Bundles the requester handshake, the shared-squarer link and the
//           response channel of the scheduler.
// Signals : req_valid/req_ready/req_n  requester side (NREQ lanes)
//           sq_n/sq_n2                 operand to / result from the squarer
//           rsp_valid/rsp_id/rsp_n2    tagged result, no backpressure
// Modports: slave  - the scheduler
//           master - requesters, squarer and response consumer
// ----------------------------------------------------------------------------
interface square_rr_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int W_IN  = square_sched_pkg::W_IN,
    parameter int W_OUT = square_sched_pkg::W_OUT,
    parameter int ID_W  = square_sched_pkg::id_w(NREQ)
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W_IN-1:0] req_n;
    logic [W_IN-1:0]      sq_n;
    logic [W_OUT-1:0]     sq_n2;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [W_OUT-1:0]     rsp_n2;

    modport slave (
        input  req_valid, req_n, sq_n2,
        output req_ready, sq_n, rsp_valid, rsp_id, rsp_n2
    );

    modport master (
        output req_valid, req_n, sq_n2,
        input  req_ready, sq_n, rsp_valid, rsp_id, rsp_n2
    );
endinterface

// File: rtl/square_rr_scheduler_arb.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purpose : Combinational round-robin pick. Searches i_req upward from i_ptr,
//           wrapping N-1 -> 0, and grants the first set bit.
// Ports   : i_req     [N]   request vector
//           i_ptr     [IW]  search start index (held by the caller)
//           o_gnt     [N]   one-hot grant, zero when nothing requests
//           o_gnt_idx [IW]  index of the granted requester
//           o_any     1     some requester was granted
// ----------------------------------------------------------------------------
module rr_arbiter
    import square_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = id_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_any
);
    // One extra bit so ptr+k never overflows before the wrap subtraction.
    logic [IW:0] w_idx;

    always_comb begin
        o_any     = 1'b0;
        o_gnt_idx = '0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(N))
                w_idx = w_idx - (IW+1)'(N);
            if (!o_any && i_req[w_idx[IW-1:0]]) begin
                o_any     = 1'b1;
                o_gnt_idx = w_idx[IW-1:0];
            end
        end
        o_gnt = o_any ? ({{(N-1){1'b0}}, 1'b1} << o_gnt_idx) : '0;
    end

endmodule

// File: rtl/square_rr_scheduler.sv
// ----------------------------------------------------------------------------
// square_rr_scheduler
// Purpose : Shares one registered squarer between NREQ requesters. Grants one
//           requester per cycle round-robin, drives its operand to the
//           squarer, tracks the in-flight op with a {vld,id} tag pipeline and
//           returns the result tagged with the requester index.
// Ports   : clk   rising-edge clock
//           rstn  asynchronous active-low reset
//           bus   square_rr_scheduler_if.slave
//                   req_valid/req_ready/req_n  requester handshake
//                   sq_n/sq_n2                 squarer operand/result
//                   rsp_valid/rsp_id/rsp_n2    tagged response
// Timing  : handshake in cycle t -> sq_n valid t+1 -> sq_n2 valid t+1+LAT
//           -> rsp_valid high in t+LAT+2.
// ----------------------------------------------------------------------------
module square_rr_scheduler
    import square_sched_pkg::id_w;
#(
    parameter int NREQ  = 4,
    parameter int LAT   = 1,
    parameter int W_IN  = square_sched_pkg::W_IN,
    parameter int W_OUT = square_sched_pkg::W_OUT
) (
    input  logic                   clk,
    input  logic                   rstn,
    square_rr_scheduler_if.slave   bus
);
    localparam int ID_W = id_w(NREQ);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]  r_ptr;
    logic [W_IN-1:0]  r_sq_n;
    tag_t [LAT:0]     r_tag_pipe;   // stage LAT lines up with valid sq_n2
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [W_OUT-1:0] r_rsp_n2;

    logic [NREQ-1:0]  w_gnt;
    logic [ID_W-1:0]  w_gnt_idx;
    logic             w_any;
    logic [W_IN-1:0]  w_opnd;
    tag_t             w_tag_in;
    tag_t             w_tag_out;

    rr_arbiter #(.N(NREQ)) u_arb (
        .i_req     (bus.req_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // Grants only go to valid requesters, so any grant is a handshake.
    assign bus.req_ready = rstn ? w_gnt : '0;
    assign w_opnd        = bus.req_n[w_gnt_idx*W_IN +: W_IN];
    assign w_tag_in      = '{vld: w_any, id: w_gnt_idx};
    assign w_tag_out     = r_tag_pipe[LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr       <= '0;
            r_sq_n      <= '0;
            r_tag_pipe  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_n2    <= '0;
        end else begin
            if (w_any) begin
                r_ptr  <= (w_gnt_idx == ID_W'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
                r_sq_n <= w_opnd;
            end
            r_tag_pipe  <= {r_tag_pipe[LAT-1:0], w_tag_in};
            r_rsp_valid <= w_tag_out.vld;
            if (w_tag_out.vld) begin
                r_rsp_id <= w_tag_out.id;
                r_rsp_n2 <= bus.sq_n2;
            end
        end
    end

    assign bus.sq_n      = r_sq_n;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_n2    = r_rsp_n2;

endmodule

// File: tb/tb_square_rr_scheduler.sv
module tb_square_rr_scheduler;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    // DUT A: NREQ=4, LAT=1. DUT B: NREQ=3, LAT=2.
    square_rr_scheduler_if #(.NREQ(4)) ifa ();
    square_rr_scheduler_if #(.NREQ(3)) ifb ();

    square_rr_scheduler #(.NREQ(4), .LAT(1)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa.slave));
    square_rr_scheduler #(.NREQ(3), .LAT(2)) dut_b (.clk(clk), .rstn(rstn), .bus(ifb.slave));

    // External squarer models: n2 = n*n after LAT clocks.
    logic [7:0] b_s1;
    always @(posedge clk) ifa.sq_n2 <= 8'(ifa.sq_n) * 8'(ifa.sq_n);
    always @(posedge clk) begin
        b_s1     <= 8'(ifb.sq_n) * 8'(ifb.sq_n);
        ifb.sq_n2 <= b_s1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: responses expected at an absolute cycle number.
    typedef struct { int due; int id; int n2; } exp_t;

    exp_t qa[$];
    int   cyc_a = 0, ptr_a = 0, sqn_a = 0, last_id_a = 0, last_n2_a = 0;
    int   hs_a = -1, g_a = 0;
    bit   any_a = 0;

    exp_t qb[$];
    int   cyc_b = 0, ptr_b = 0, sqn_b = 0, last_id_b = 0, last_n2_b = 0;
    int   hs_b = -1, g_b = 0;
    bit   any_b = 0;

    task automatic set_a(input int i, input logic v, input logic [3:0] n);
        ifa.req_valid[i] = v;
        ifa.req_n[i*4 +: 4] = n;
    endtask

    task automatic set_b(input int i, input logic v, input logic [3:0] n);
        ifb.req_valid[i] = v;
        ifb.req_n[i*4 +: 4] = n;
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete();
        ptr_a = 0; sqn_a = 0; last_id_a = 0; last_n2_a = 0;
        ptr_b = 0; sqn_b = 0; last_id_b = 0; last_n2_b = 0;
    endtask

    task automatic check_a();
        exp_t e;
        logic [3:0] er;
        any_a = 0; g_a = 0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (ptr_a + k) % 4;
            if (!any_a && ifa.req_valid[i]) begin any_a = 1; g_a = i; end
        end
        er = (rstn && any_a) ? 4'(1 << g_a) : 4'b0;
        chk("a_req_ready", 32'(ifa.req_ready), 32'(er));
        chk("a_sq_n", 32'(ifa.sq_n), sqn_a);
        if (qa.size() > 0 && qa[0].due == cyc_a) begin
            e = qa.pop_front();
            chk("a_rsp_valid", 32'(ifa.rsp_valid), 1);
            chk("a_rsp_id", 32'(ifa.rsp_id), e.id);
            chk("a_rsp_n2", 32'(ifa.rsp_n2), e.n2);
            last_id_a = e.id; last_n2_a = e.n2;
        end else begin
            chk("a_rsp_valid_idle", 32'(ifa.rsp_valid), 0);
            chk("a_rsp_id_hold", 32'(ifa.rsp_id), last_id_a);
            chk("a_rsp_n2_hold", 32'(ifa.rsp_n2), last_n2_a);
        end
    endtask

    task automatic tick_a();
        int n;
        @(negedge clk);
        check_a();
        @(posedge clk);
        hs_a = -1;
        if (rstn && any_a) begin
            n = int'(ifa.req_n[g_a*4 +: 4]);
            qa.push_back('{cyc_a + 3, g_a, n * n});
            sqn_a = n; hs_a = g_a; ptr_a = (g_a + 1) % 4;
        end
        cyc_a++;
        #1;
    endtask

    task automatic tick_b();
        exp_t e;
        logic [2:0] er;
        int n;
        @(negedge clk);
        any_b = 0; g_b = 0;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (ptr_b + k) % 3;
            if (!any_b && ifb.req_valid[i]) begin any_b = 1; g_b = i; end
        end
        er = (rstn && any_b) ? 3'(1 << g_b) : 3'b0;
        chk("b_req_ready", 32'(ifb.req_ready), 32'(er));
        chk("b_sq_n", 32'(ifb.sq_n), sqn_b);
        if (qb.size() > 0 && qb[0].due == cyc_b) begin
            e = qb.pop_front();
            chk("b_rsp_valid", 32'(ifb.rsp_valid), 1);
            chk("b_rsp_id", 32'(ifb.rsp_id), e.id);
            chk("b_rsp_n2", 32'(ifb.rsp_n2), e.n2);
            last_id_b = e.id; last_n2_b = e.n2;
        end else begin
            chk("b_rsp_valid_idle", 32'(ifb.rsp_valid), 0);
            chk("b_rsp_id_hold", 32'(ifb.rsp_id), last_id_b);
            chk("b_rsp_n2_hold", 32'(ifb.rsp_n2), last_n2_b);
        end
        @(posedge clk);
        hs_b = -1;
        if (rstn && any_b) begin
            n = int'(ifb.req_n[g_b*4 +: 4]);
            qb.push_back('{cyc_b + 4, g_b, n * n});
            sqn_b = n; hs_b = g_b; ptr_b = (g_b + 1) % 3;
        end
        cyc_b++;
        #1;
    endtask

    // Asynchronous reset assertion, checked immediately (no clock edge).
    task automatic do_reset(input int hold);
        rstn = 1'b0;
        model_reset();
        #1;
        chk("rst_rsp_valid", 32'(ifa.rsp_valid), 0);
        chk("rst_req_ready", 32'(ifa.req_ready), 0);
        chk("rst_sq_n", 32'(ifa.sq_n), 0);
        chk("rst_rsp_id", 32'(ifa.rsp_id), 0);
        chk("rst_rsp_n2", 32'(ifa.rsp_n2), 0);
        repeat (hold) tick_a();
        @(posedge clk); #1;
        cyc_a++;
        rstn = 1'b1;
    endtask

    initial begin
        ifa.req_valid = '0; ifa.req_n = '0;
        ifb.req_valid = '0; ifb.req_n = '0;

        // 1: reset for 100 ns, then idle
        #1 rstn = 1'b0;
        #100;
        chk("t1_rsp_valid", 32'(ifa.rsp_valid), 0);
        chk("t1_rsp_id", 32'(ifa.rsp_id), 0);
        chk("t1_rsp_n2", 32'(ifa.rsp_n2), 0);
        chk("t1_sq_n", 32'(ifa.sq_n), 0);
        chk("t1_req_ready", 32'(ifa.req_ready), 0);
        chk("t1_b_rsp_valid", 32'(ifb.rsp_valid), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (20) tick_a();

        // 2: only requester 2, n = 0..15 back-to-back
        set_a(2, 1'b1, 4'd0);
        for (int n = 0; n < 16; n++) begin
            tick_a();
            chk("t2_grant", hs_a, 2);
            if (n < 15) set_a(2, 1'b1, 4'(n + 1));
            else        set_a(2, 1'b0, 4'd0);
        end
        repeat (4) tick_a();

        // 3: all valid from reset, n = i+5
        do_reset(2);
        for (int i = 0; i < 4; i++) set_a(i, 1'b1, 4'(i + 5));
        for (int k = 0; k < 12; k++) begin
            tick_a();
            chk("t3_grant", hs_a, k % 4);
        end

        // 4: only 1 and 3 after a grant to 3 -> wrap to 1
        set_a(0, 1'b0, 4'd0);
        set_a(2, 1'b0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            tick_a();
            chk("t4_grant", hs_a, (k % 2 == 0) ? 1 : 3);
        end
        set_a(1, 1'b0, 4'd0);
        set_a(3, 1'b0, 4'd0);
        repeat (4) tick_a();

        // 5: issue to 0 and 1, then reset; nothing may come back
        set_a(0, 1'b1, 4'd9);
        set_a(1, 1'b1, 4'd11);
        tick_a();
        chk("t5_grant0", hs_a, 0);
        set_a(0, 1'b0, 4'd0);
        tick_a();
        chk("t5_grant1", hs_a, 1);
        set_a(1, 1'b0, 4'd0);
        do_reset(2);
        repeat (6) tick_a();

        // Randomized traffic, one reset somewhere in the middle
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++)
                if (!ifa.req_valid[i] || hs_a == i)
                    set_a(i, 1'($urandom_range(1, 0)), 4'($urandom));
            if (c == 150) begin
                ifa.req_valid = '0;
                do_reset(1);
            end
            tick_a();
        end
        ifa.req_valid = '0;
        repeat (5) tick_a();
        chk("rand_drained", qa.size(), 0);

        // 6: NREQ=3, LAT=2, all valid
        set_b(0, 1'b1, 4'd15);
        set_b(1, 1'b1, 4'd10);
        set_b(2, 1'b1, 4'd4);
        for (int k = 0; k < 4; k++) begin
            tick_b();
            chk("t6_grant", hs_b, k % 3);
        end
        ifb.req_valid = '0;
        repeat (7) tick_b();
        chk("t6_drained", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net in case a wait never returns.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
